mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width (legal: even, >= 4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have port Funct  input  6  R-type function code selecting the operation.
REQ-006 SHALL have port a  input  WIDTH  rs operand (dividend / multiplicand / MT* data).
REQ-007 SHALL have port b  input  WIDTH  rt operand (divisor / multiplier).
REQ-008 SHALL have port busy_o  output  1  high while a multiply or divide is in progress.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse: HI/LO updated by MULT*/DIV*.
REQ-010 SHALL have port invalid_o  output  1  one-cycle pulse: start with an unsupported Funct.
REQ-011 SHALL have port hi_o, lo_o  output  WIDTH  each; the architectural HI and LO registers.
REQ-012 SHALL have port result_o  output  WIDTH  registered MFHI/MFLO read data.

Function
REQ-013 SHALL decode Funct: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO; any other code is unsupported.
REQ-014 SHALL implement FSM states IDLE, CALC, FIX; reset state IDLE.
REQ-015 SHALL, in IDLE on start with MULT*/DIV* at edge E0, latch operands, magnitudes (signed ops) and op type, enter CALC, and set busy_o high from E0.
REQ-016 SHALL perform one radix-2 step per cycle in CALC (shift-add multiply, restoring divide) for exactly WIDTH cycles, then enter FIX.
REQ-017 SHALL, in FIX, apply sign correction, write HI/LO, pulse done_o, clear busy_o and return to IDLE; done_o is high in the cycle after edge E0+WIDTH+1.
REQ-018 SHALL produce {HI,LO} = full 2*WIDTH-bit product for MULT (signed) and MULTU (unsigned).
REQ-019 SHALL produce LO = quotient, HI = remainder for DIV/DIVU; signed quotient truncates toward zero, remainder takes dividend's sign.
REQ-020 SHALL give signed most-negative / -1: LO = most-negative value (wrap), HI = 0.
REQ-021 SHALL, for divisor 0 (DIV or DIVU), skip CALC: go IDLE->FIX directly, LO = all ones, HI = a; done_o two cycles after accept edge.
REQ-022 SHALL execute MTHI/MTLO in IDLE in one cycle: HI or LO <= a at the accept edge; no busy_o, no done_o.
REQ-023 SHALL execute MFHI/MFLO in IDLE: result_o <= HI or LO at the accept edge; result_o otherwise holds.
REQ-024 SHALL ignore start (any Funct) while busy_o is high; no state, output or pulse change.
REQ-025 SHALL pulse invalid_o one cycle after an unsupported Funct is accepted in IDLE; HI/LO/result_o unchanged.
REQ-026 SHALL keep HI/LO unchanged during CALC; partial results are held only in internal registers.
REQ-027 SHALL permit a new start in the cycle done_o is high (back-to-back, FSM already IDLE).

Reset
REQ-028 SHALL, on rst_n low, immediately (asynchronously) force IDLE, busy_o=0, done_o=0, invalid_o=0, hi_o=0, lo_o=0, result_o=0, iteration counter 0.
REQ-029 SHALL abort any in-progress operation on reset with no partial HI/LO write; first legal start after rst_n rises is accepted normally.

Verification (WIDTH=32)
REQ-030 SHALL cover MULT a=0xFFFFFFFD(-3), b=7 -> done_o at E0+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU same operands -> HI=0x00000006, LO=0xFFFFFFEB.
REQ-031 SHALL cover DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 SHALL cover DIVU a=100, b=0 -> done_o two cycles after accept, LO=0xFFFFFFFF, HI=100.
REQ-033 SHALL cover MTHI a=0x1234 then MFHI -> hi_o=0x1234 after first edge, result_o=0x1234 after second; no done_o.
REQ-034 SHALL cover start MULT during busy (mid-CALC) and Funct=100000 in IDLE -> first ignored (result from original op only), second pulses invalid_o with HI/LO unchanged.
REQ-035 SHALL cover rst_n low at cycle 10 of a DIVU -> outputs zero immediately, busy_o=0, no done_o; subsequent MULTU 3x5 gives LO=15, HI=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: radix-2 shift-add multiply
// and restoring divide on operand magnitudes, with sign correction at the end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy_o,
  output logic             done_o,
  output logic             invalid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q, result_q;
  logic [WIDTH-1:0] acc_q, acc_d, shreg_q, shreg_d, opnd_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, neg_p_q, neg_r_q, div0_q;
  logic             busy_q, done_q, invalid_q;

  // 0110xx are MULT/MULTU/DIV/DIVU; bit 1 selects divide, bit 0 selects unsigned.
  logic             is_md, op_div, op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_md     = (Funct[5:2] == 4'b0110);
  assign op_div    = Funct[1];
  assign op_signed = ~Funct[0];
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

  // acc holds the upper product half / partial remainder; shreg holds the
  // multiplier / dividend, shifting out as product bits / quotient bits enter.
  logic [WIDTH:0] sum, shifted, trial;

  always_comb begin
    acc_d   = acc_q;
    shreg_d = shreg_q;
    sum     = '0;
    shifted = '0;
    trial   = '0;
    if (is_div_q) begin
      shifted = {acc_q, shreg_q[WIDTH-1]};
      trial   = shifted - {1'b0, opnd_q};
      if (!trial[WIDTH]) begin
        acc_d   = trial[WIDTH-1:0];
        shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d   = shifted[WIDTH-1:0];
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc_q} + (shreg_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      acc_d   = sum[WIDTH:1];
      shreg_d = {sum[0], shreg_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_neg;
  assign prod     = {acc_q, shreg_q};
  assign prod_neg = -prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_p_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_md) begin
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              acc_q    <= '0;
              is_div_q <= op_div;
              neg_p_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_q  <= op_signed && a[WIDTH-1];
              opnd_q   <= op_div ? b_mag : a_mag;
              if (op_div && (b == '0)) begin
                div0_q  <= 1'b1;
                shreg_q <= a;
                state_q <= FIX;
              end else begin
                div0_q  <= 1'b0;
                shreg_q <= op_div ? a_mag : b_mag;
                state_q <= CALC;
              end
            end else begin
              case (Funct)
                6'b010000: result_q  <= hi_q;
                6'b010001: hi_q      <= a;
                6'b010010: result_q  <= lo_q;
                6'b010011: lo_q      <= a;
                default:   invalid_q <= 1'b1;
              endcase
            end
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          if (div0_q) begin
            hi_q <= shreg_q;
            lo_q <= '1;
          end else if (is_div_q) begin
            hi_q <= neg_r_q ? -acc_q : acc_q;
            lo_q <= neg_p_q ? -shreg_q : shreg_q;
          end else begin
            {hi_q, lo_q} <= neg_p_q ? prod_neg : prod;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign invalid_o = invalid_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign result_o  = result_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit (WIDTH=32): directed corner cases plus random ops
// checked against a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;

  localparam logic [5:0] F_MULT  = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000, F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010, F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [5:0]  Funct;
  logic [31:0] a, b;
  logic        busy_o, done_o, invalid_o;
  logic [31:0] hi_o, lo_o, result_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo, m_res;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Funct(Funct), .a(a), .b(b),
    .busy_o(busy_o), .done_o(done_o), .invalid_o(invalid_o),
    .hi_o(hi_o), .lo_o(lo_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: whole-operand arithmetic on 64-bit integers.
  task automatic model_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] eh, output logic [31:0] el);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    p  = '0;
    eh = '0;
    el = '0;
    case (f)
      F_MULT:  begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      F_MULTU: begin p = ux * uy; eh = p[63:32]; el = p[31:0]; end
      F_DIV:   if (y == 0) begin eh = x; el = '1; end
               else begin el = 32'(sx / sy); eh = 32'(sx % sy); end
      default: if (y == 0) begin eh = x; el = '1; end
               else begin el = 32'(ux / uy); eh = 32'(ux % uy); end
    endcase
  endtask

  // Issues one multiply/divide; optionally pokes a MULT start while busy.
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y, input int inject_at);
    logic [31:0] eh, el;
    int n, exp_lat;
    bit hold_ok;
    model_md(f, x, y, eh, el);
    exp_lat = (f[1] && y == 0) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; Funct = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    hold_ok = 1'b1;
    n = 0;
    while (!done_o && n < 100) begin
      if (hi_o !== m_hi || lo_o !== m_lo) hold_ok = 1'b0;
      if (n == inject_at) begin
        start = 1'b1; Funct = F_MULT; a = 32'd5; b = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_hold"}, 32'(hold_ok), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_hi"}, hi_o, eh);
    chk({tag, "_lo"}, lo_o, el);
    chk({tag, "_nbusy"}, 32'(busy_o), 32'd0);
    m_hi = eh;
    m_lo = el;
    $display("[TB] %s f=%b a=%h b=%h -> hi=%h lo=%h lat=%0d", tag, f, x, y, hi_o, lo_o, n);
  endtask

  // Single-cycle IDLE ops: MT*, MF* and unsupported codes.
  task automatic run_mx(input string tag, input logic [5:0] f, input logic [31:0] x);
    bit exp_inv;
    exp_inv = 1'b0;
    case (f)
      F_MTHI:  m_hi  = x;
      F_MTLO:  m_lo  = x;
      F_MFHI:  m_res = m_hi;
      F_MFLO:  m_res = m_lo;
      default: exp_inv = 1'b1;
    endcase
    @(negedge clk);
    start = 1'b1; Funct = f; a = x; b = ~x;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_hi"}, hi_o, m_hi);
    chk({tag, "_lo"}, lo_o, m_lo);
    chk({tag, "_res"}, result_o, m_res);
    chk({tag, "_inv"}, 32'(invalid_o), 32'(exp_inv));
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    if (exp_inv) begin
      @(posedge clk); #1;
      chk({tag, "_invpulse"}, 32'(invalid_o), 32'd0);
    end
    $display("[TB] %s f=%b a=%h -> hi=%h lo=%h res=%h inv=%0b", tag, f, x, hi_o, lo_o, result_o, exp_inv);
  endtask

  initial begin
    logic [5:0]  f;
    logic [31:0] x, y;
    int r;
    m_hi = '0; m_lo = '0; m_res = '0;
    rst_n = 1'b0; start = 1'b0; Funct = '0; a = '0; b = '0;
    #3;
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_res", result_o, 32'd0);
    chk("rst_flags", {29'd0, busy_o, done_o, invalid_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_md("mult_m3x7", F_MULT, 32'hFFFFFFFD, 32'd7, -1);
    run_md("multu_m3x7", F_MULTU, 32'hFFFFFFFD, 32'd7, -1);
    run_md("div_m7d2", F_DIV, 32'hFFFFFFF9, 32'd2, -1);
    run_md("div_minneg", F_DIV, 32'h80000000, 32'hFFFFFFFF, -1);
    run_md("divu_by0", F_DIVU, 32'd100, 32'd0, -1);
    run_md("div_by0", F_DIV, 32'hFFFFFF00, 32'd0, -1);
    run_mx("mthi", F_MTHI, 32'h1234);
    run_mx("mfhi", F_MFHI, 32'h0);
    run_mx("mtlo", F_MTLO, 32'hCAFE0001);
    run_mx("mflo", F_MFLO, 32'h0);
    run_md("divu_inject", F_DIVU, 32'd1000, 32'd7, 5);
    run_mx("bad_funct", 6'b100000, 32'h5555AAAA);

    // Reset in the middle of a divide: outputs clear at once, no done follows.
    @(negedge clk);
    start = 1'b1; Funct = F_DIVU; a = 32'hFFFF0000; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi_o, 32'd0);
    chk("arst_lo", lo_o, 32'd0);
    chk("arst_res", result_o, 32'd0);
    chk("arst_flags", {29'd0, busy_o, done_o, invalid_o}, 32'd0);
    m_hi = '0; m_lo = '0; m_res = '0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("arst_nodone", {30'd0, busy_o, done_o}, 32'd0);
    end
    run_md("multu_3x5", F_MULTU, 32'd3, 32'd5, -1);

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) y = '0;
      if (r < 4) begin
        f = {4'b0110, 2'(r)};
        run_md($sformatf("rnd%0d_md", i), f, x, y, -1);
      end else if (r < 8) begin
        f = {4'b0100, 2'(r - 4)};
        run_mx($sformatf("rnd%0d_mx", i), f, x);
      end else begin
        f = 6'($urandom_range(32, 63));
        run_mx($sformatf("rnd%0d_bad", i), f, x);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
